snoop_bus_arbiter: RTL

- Parametrised shared-bus arbiter and snoop interconnect for NUM_CORES processor tiles, each containing one L1 cache subsystem.
- Collects per-core request, bus-operation, address, data, hit and flush signals.
- Grants the bus round-robin to one owner at a time and broadcasts the owner's transaction to all other cores.
- Aggregates snoop hits and forwards flush data.

---
 rtl/snoop_bus_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/snoop_bus_arbiter.sv
// Round-robin shared-bus arbiter with snoop broadcast, hit aggregation and flush forwarding.
// Optional forced release after MAX_HOLD owned cycles: define BUS_TIMEOUT_EN.
module snoop_bus_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_HOLD  = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CORES-1:0]           req_core,
    input  logic [NUM_CORES*DATA_W-1:0]    core_data_out,
    input  logic [NUM_CORES*ADDR_W-1:0]    core_address_out,
    input  logic [NUM_CORES*2-1:0]         core_operation_out,
    input  logic [NUM_CORES-1:0]           core_hit_out,
    input  logic [NUM_CORES-1:0]           core_flush,
    output logic [NUM_CORES-1:0]           grant,
    output logic [DATA_W-1:0]              bus_data_in,
    output logic [ADDR_W-1:0]              bus_address_in,
    output logic [NUM_CORES*2-1:0]         bus_operation_in,
    output logic [NUM_CORES-1:0]           cache_hit_in,
    output logic [$clog2(NUM_CORES)-1:0]   owner_id,
    output logic                           bus_busy,
    output logic                           hold_timeout
);

    localparam int IDW = $clog2(NUM_CORES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_REL  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_CORES-1:0]    grant_q, grant_d;
    logic [IDW-1:0]          owner_q, owner_d;
    logic [IDW-1:0]          rr_q, rr_d;
    logic                    busy_q, busy_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [NUM_CORES*2-1:0]  op_q, op_d;
    logic [NUM_CORES-1:0]    hit_q, hit_d;

    logic                    pick_vld;
    logic [IDW-1:0]          pick_idx;
    int                      cand;
    logic                    fl_vld;
    logic [IDW-1:0]          fl_idx;
    logic [1:0]              own_op;
    logic                    bcast;
    logic                    hold_expire;

    // Circular search for the first requester at or after rr_q
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = (int'(rr_q) + k) % NUM_CORES;
            if (!pick_vld && req_core[cand]) begin
                pick_vld = 1'b1;
                pick_idx = IDW'(cand);
            end
        end
    end

    always_comb begin
        fl_vld = 1'b0;
        fl_idx = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!fl_vld && core_flush[i] && (IDW'(i) != owner_q)) begin
                fl_vld = 1'b1;
                fl_idx = IDW'(i);
            end
        end
    end

    always_comb begin
        hit_d = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            hit_d[i] = |(core_hit_out & ~(NUM_CORES'(1) << i));
        end
    end

    assign own_op = core_operation_out[int'(owner_q)*2 +: 2];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d = S_OWN;
                    grant_d = NUM_CORES'(1) << pick_idx;
                    owner_d = pick_idx;
                end
            end
            S_OWN: begin
                if (!req_core[owner_q] || hold_expire) begin
                    state_d = S_REL;
                    grant_d = '0;
                end
            end
            S_REL: begin
                state_d = S_IDLE;
                rr_d    = (owner_q == IDW'(NUM_CORES - 1)) ? '0 : owner_q + 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Only a cycle that stays in OWN is forwarded; release cycles show BusNoN
    assign bcast = (state_q == S_OWN) && (state_d == S_OWN);

    always_comb begin
        busy_d = (state_d == S_OWN);
        op_d   = '1;
        data_d = data_q;
        addr_d = addr_q;
        if (bcast) begin
            addr_d = core_address_out[int'(owner_q)*ADDR_W +: ADDR_W];
            data_d = fl_vld ? core_data_out[int'(fl_idx)*DATA_W +: DATA_W]
                            : core_data_out[int'(owner_q)*DATA_W +: DATA_W];
            for (int i = 0; i < NUM_CORES; i++) begin
                op_d[i*2 +: 2] = (IDW'(i) == owner_q) ? 2'b11 : own_op;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            op_q    <= '1;
            hit_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            hit_q   <= hit_d;
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;

    assign hold_expire = (state_q == S_OWN) && (cnt_q == CW'(MAX_HOLD - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_OWN) begin
            cnt_d = cnt_q + 1'b1;
        end else if (state_d == S_OWN) begin
            cnt_d = '0;
        end
        tmo_d = hold_expire && req_core[owner_q];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign hold_timeout = tmo_q;
`else
    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("MAX_HOLD must be at least 1");
    end

    assign hold_expire  = 1'b0;
    assign hold_timeout = 1'b0;
`endif

    if (NUM_CORES < 2 || NUM_CORES > 16) begin : g_bad_cores
        $error("NUM_CORES must be in 2..16");
    end

    assign grant            = grant_q;
    assign owner_id         = owner_q;
    assign bus_busy         = busy_q;
    assign bus_data_in      = data_q;
    assign bus_address_in   = addr_q;
    assign bus_operation_in = op_q;
    assign cache_hit_in     = hit_q;

endmodule
